mer_sweep_controller: RTL
=========================

Name: mer_sweep_controller

Overview:
Sequences an MER measurement sweep around the ISI-injection channel model. It drives the channel's isi_power input through a linear sweep of NUM_STEPS settings. At each setting it waits for the channel pipeline to flush, then accumulates squared error and squared errorless decision variable over 2^LOG2_N symbols. Each pair of energy sums is handed to the downstream MER calculator through a valid/ready handshake. The block sits between the test-control registers and the channel model, in the symbol clock-enable domain.

Parameters:
DATA_WIDTH, 18, width of isi_power, error and errorless samples (1s17 format)
LOG2_N, 10, log2 of symbols accumulated per step
SETTLE_SYMS, 4, symbol enables discarded after each isi_power change (channel latency plus margin); legal range 1..255
NUM_STEPS, 8, isi_power settings per sweep; legal range 1..256

Ports:
clk  in  1  system clock
reset  in  1  async active-low reset
clk_en  in  1  symbol-rate enable; samples valid only on cycles where it is high
start  in  1  single-cycle pulse that begins a sweep
abort  in  1  synchronous sweep cancel
isi_start  in  DATA_WIDTH  signed first isi_power value
isi_step  in  DATA_WIDTH  signed increment per step
error  in  DATA_WIDTH  signed channel error sample
errorless  in  DATA_WIDTH  signed errorless decision variable
isi_power  out  DATA_WIDTH  signed, registered, drives the channel model
busy  out  1  high in any state except IDLE
step_idx  out  8  index of the current or reported step
sum_err_sq  out  2*DATA_WIDTH-1+LOG2_N  unsigned sum of error squared
sum_sig_sq  out  2*DATA_WIDTH-1+LOG2_N  unsigned sum of errorless squared
result_valid  out  1  result handshake valid
result_ready  in  1  result handshake ready
done  out  1  one-clk pulse at the end of a sweep
err_peak  out  DATA_WIDTH  unsigned peak of |error| (see Optional Feature)

Behaviour:
- Reset (async, active-low): state IDLE. All outputs 0, including isi_power, sums, step_idx, result_valid, done and err_peak.
- Interface: reset is asynchronous, active-low, named reset; clock is clk.
- States: IDLE, LOAD, SETTLE, ACCUM, REPORT.
- IDLE -> LOAD: on start=1. Load isi_power = sat(isi_start) and step_idx = 0.
- LOAD -> SETTLE: after one clk. Clear both accumulators and the symbol counter.
- SETTLE -> ACCUM: after SETTLE_SYMS clk_en cycles. clk_en=0 cycles do not count.
- ACCUM: on each clk_en cycle, add error*error and errorless*errorless. Each square is exact, 2*DATA_WIDTH-1 bits unsigned; the most negative input squares to 2^(2*DATA_WIDTH-2) without overflow. After 2^LOG2_N enables, move to REPORT. The accumulators cannot overflow.
- REPORT: result_valid=1; sums and step_idx stay stable until result_valid && result_ready. clk_en is ignored while stalled.
- On handshake, last step (step_idx == NUM_STEPS-1): pulse done, go to IDLE. isi_power holds its final value.
- On handshake, otherwise: step_idx+1, isi_power = sat(isi_power + isi_step), go to LOAD.
- sat(): compute in DATA_WIDTH+1 bits, clamp to [0, 2^(DATA_WIDTH-1)-1]. Negative results clamp to 0.
- start while busy: ignored.
- abort: from any non-IDLE state, go to IDLE next clk. result_valid drops immediately, done is not pulsed, isi_power is held.
- abort and start in the same clk: abort wins.
- Handshake and abort in the same clk: the handshake is treated as accepted, and abort still wins, so done is not pulsed.
- First result_valid appears no earlier than 1 + SETTLE_SYMS + 2^LOG2_N clk_en cycles after start.

Optional Feature:
Macro MER_PEAK_DETECT_EN.
- Defined: err_peak tracks max |error| over each ACCUM window. Cleared in LOAD, held through REPORT. |-2^(DATA_WIDTH-1)| saturates to 2^(DATA_WIDTH-1)-1.
- Undefined: err_peak is tied to 0 and no peak logic is built.

Test Plan:
- Setup for all: LOG2_N=4, SETTLE_SYMS=4, NUM_STEPS=2, clk_en every 16 clk, result_ready=1.
- Constant inputs: error=1000, errorless=32768 -> sum_err_sq=16000000, sum_sig_sq=17179869184 on both steps; two results, then one done pulse.
- isi_start=9268, isi_step=1000 -> isi_power 9268 during step 0, 10268 during step 1, holds 10268 after done.
- isi_start=131000, isi_step=1000 -> step 1 isi_power=131071. isi_start=500, isi_step=-1000 -> step 1 isi_power=0.
- error=-131072 constant -> sum_err_sq=16*2^34=274877906944, no wrap. With macro defined, err_peak=131071.
- result_ready=0 for 100 clk in REPORT -> result_valid, sums and step_idx stable; no clk_en is consumed; the next step starts after ready.
- abort mid-ACCUM of step 0 -> IDLE next clk, busy=0, no result_valid, no done. A new start then runs a full sweep correctly. Async reset mid-SETTLE -> all outputs 0.

Source files
------------

// File: rtl/mer_sweep_controller.sv
// MER sweep sequencer: steps isi_power through NUM_STEPS settings, settles, accumulates
// error/errorless energy per step and reports via valid/ready. Optional MER_PEAK_DETECT_EN adds |error| peak.
module mer_sweep_controller #(
  parameter int DATA_WIDTH  = 18,
  parameter int LOG2_N      = 10,
  parameter int SETTLE_SYMS = 4,
  parameter int NUM_STEPS   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clk_en,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic signed [DATA_WIDTH-1:0]          isi_start,
  input  logic signed [DATA_WIDTH-1:0]          isi_step,
  input  logic signed [DATA_WIDTH-1:0]          error,
  input  logic signed [DATA_WIDTH-1:0]          errorless,
  output logic signed [DATA_WIDTH-1:0]          isi_power,
  output logic                                  busy,
  output logic [7:0]                            step_idx,
  output logic [2*DATA_WIDTH-1+LOG2_N-1:0]      sum_err_sq,
  output logic [2*DATA_WIDTH-1+LOG2_N-1:0]      sum_sig_sq,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  done,
  output logic [DATA_WIDTH-1:0]                 err_peak,
  output logic [2:0]                            dbg_state
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = 2*DATA_WIDTH-1+LOG2_N;
  localparam int CW = (LOG2_N > 8) ? LOG2_N : 8;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SYMS-1);
  localparam logic [CW-1:0] ACCUM_LAST  = CW'((2**LOG2_N)-1);
  localparam logic [7:0]    STEP_LAST   = 8'(NUM_STEPS-1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_ACCUM, S_REPORT} state_t;

  state_t                 state_q;
  logic signed [DW-1:0]   isi_q;
  logic [7:0]             step_q;
  logic [SW-1:0]          sum_err_q, sum_sig_q;
  logic [SW-1:0]          sum_err_d, sum_sig_d;
  logic [CW-1:0]          cnt_q;
  logic                   valid_q, done_q;
  logic signed [2*DW-1:0] err_prod, sig_prod;

  // Clamp a DW+1-bit signed sum into the non-negative isi_power range.
  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW])        return '0;
    else if (v[DW-1]) return {1'b0, {(DW-1){1'b1}}};
    else              return v[DW-1:0];
  endfunction

  // Squares are non-negative and fit 2*DW-1 bits, so the product MSB is always zero.
  assign err_prod  = error * error;
  assign sig_prod  = errorless * errorless;
  assign sum_err_d = sum_err_q + SW'($unsigned(err_prod));
  assign sum_sig_d = sum_sig_q + SW'($unsigned(sig_prod));

`ifdef MER_PEAK_DETECT_EN
  logic [DW-1:0] peak_q, err_abs;
  always_comb begin
    err_abs = $unsigned(error);
    if (error == {1'b1, {(DW-1){1'b0}}}) err_abs = {1'b0, {(DW-1){1'b1}}};
    else if (error[DW-1])                err_abs = $unsigned(-error);
  end
  assign err_peak = peak_q;
`else
  assign err_peak = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      isi_q     <= '0;
      step_q    <= '0;
      sum_err_q <= '0;
      sum_sig_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef MER_PEAK_DETECT_EN
      peak_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              isi_q   <= sat({isi_start[DW-1], isi_start});
              step_q  <= '0;
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            sum_err_q <= '0;
            sum_sig_q <= '0;
            cnt_q     <= '0;
`ifdef MER_PEAK_DETECT_EN
            peak_q    <= '0;
`endif
            state_q   <= S_SETTLE;
          end
          S_SETTLE: begin
            if (clk_en) begin
              if (cnt_q == SETTLE_LAST) begin
                cnt_q   <= '0;
                state_q <= S_ACCUM;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_ACCUM: begin
            if (clk_en) begin
              sum_err_q <= sum_err_d;
              sum_sig_q <= sum_sig_d;
`ifdef MER_PEAK_DETECT_EN
              if (err_abs > peak_q) peak_q <= err_abs;
`endif
              if (cnt_q == ACCUM_LAST) begin
                valid_q <= 1'b1;
                state_q <= S_REPORT;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_REPORT: begin
            // Handshake: result_valid && result_ready on a rising clk edge accepts the sums.
            if (result_ready) begin
              valid_q <= 1'b0;
              if (step_q == STEP_LAST) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                step_q  <= step_q + 8'd1;
                isi_q   <= sat({isi_q[DW-1], isi_q} + {isi_step[DW-1], isi_step});
                state_q <= S_LOAD;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign isi_power    = isi_q;
  assign busy         = (state_q != S_IDLE);
  assign step_idx     = step_q;
  assign sum_err_sq   = sum_err_q;
  assign sum_sig_sq   = sum_sig_q;
  assign result_valid = valid_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule
